// File: rtl/fpu_pkg.sv
// Shared definitions for the FP sequencer and the multi-cycle unit wrappers:
// op-class encoding, sequencer states and per-class latencies.
package fpu_pkg;

    localparam int unsigned ADD_LAT  = 3;
    localparam int unsigned MUL_LAT  = 4;
    localparam int unsigned FMA_LAT  = 5;
    localparam int unsigned DIV_LAT  = 12;
    localparam int unsigned SQRT_LAT = 16;
    localparam int          CNT_W    = 5;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_ADD  = 3'd1,
        CLS_MUL  = 3'd2,
        CLS_FMA  = 3'd3,
        CLS_DIV  = 3'd4,
        CLS_SQRT = 3'd5
    } fpu_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_e;

    // Codes 6 and 7 are undefined and behave like NONE.
    function automatic fpu_class_e to_class(logic [2:0] raw);
        case (raw)
            3'd1:    return CLS_ADD;
            3'd2:    return CLS_MUL;
            3'd3:    return CLS_FMA;
            3'd4:    return CLS_DIV;
            3'd5:    return CLS_SQRT;
            default: return CLS_NONE;
        endcase
    endfunction

    function automatic int unsigned lat_of(fpu_class_e c);
        case (c)
            CLS_ADD:  return ADD_LAT;
            CLS_MUL:  return MUL_LAT;
            CLS_FMA:  return FMA_LAT;
            CLS_DIV:  return DIV_LAT;
            CLS_SQRT: return SQRT_LAT;
            default:  return 1;
        endcase
    endfunction

    function automatic logic [4:0] start_mask(fpu_class_e c);
        case (c)
            CLS_ADD:  return 5'b00001;
            CLS_MUL:  return 5'b00010;
            CLS_FMA:  return 5'b00100;
            CLS_DIV:  return 5'b01000;
            CLS_SQRT: return 5'b10000;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// EX-side handshake between the decode/issue logic and the FP sequencer.
interface fpu_sequencer_if;

    logic        issue_valid;
    logic [2:0]  issue_class;
    logic [4:0]  issue_rd;
    logic        kill;
    logic        hold;
    logic        busy;
    logic [4:0]  unit_start;
    logic        unit_abort;
    logic [2:0]  res_sel;
    logic        result_valid;
    logic [4:0]  result_rd;
    logic [31:0] retired;

    modport master (
        output issue_valid, issue_class, issue_rd, kill, hold,
        input  busy, unit_start, unit_abort, res_sel, result_valid, result_rd, retired
    );

    modport slave (
        input  issue_valid, issue_class, issue_rd, kill, hold,
        output busy, unit_start, unit_abort, res_sel, result_valid, result_rd, retired
    );

endinterface

// File: rtl/fpu_lat_counter.sv
// Down-counter timing the selected unit's latency; zero marks the last RUN cycle.
module fpu_lat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fpu_sequencer.sv
// EX-stage controller for the multi-cycle FP units: one op in flight,
// start pulse, latency count, result presentation, kill and hold handling.
module fpu_sequencer
    import fpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fpu_sequencer_if.slave bus
);

    seq_state_e       state;
    fpu_class_e       issue_cls;
    fpu_class_e       cls_q;
    logic [4:0]       rd_q;
    logic [4:0]       start_q;
    logic             abort_q;
    logic [31:0]      retired_q;
    logic             accept;
    logic             cnt_zero;
    logic [CNT_W-1:0] load_val;

    // NOTE: each always_comb output is assigned a default first so no path infers a latch.
    always_comb begin
        issue_cls = to_class(bus.issue_class);
        accept    = 1'b0;
        if (state == S_IDLE && bus.issue_valid && !bus.kill && issue_cls != CLS_NONE) begin
            accept = 1'b1;
        end
        load_val = CNT_W'(lat_of(issue_cls) - 1);
    end

    fpu_lat_counter #(.W(CNT_W)) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.kill),
        .load     (accept),
        .load_val (load_val),
        .dec      (state == S_RUN),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cls_q     <= CLS_NONE;
            rd_q      <= '0;
            start_q   <= '0;
            abort_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            start_q <= '0;
            abort_q <= 1'b0;
            if (bus.kill) begin
                // Only an op actually executing in a unit needs aborting.
                state   <= S_IDLE;
                abort_q <= (state == S_RUN);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state   <= S_RUN;
                            cls_q   <= issue_cls;
                            rd_q    <= bus.issue_rd;
                            start_q <= start_mask(issue_cls);
                        end
                    end
                    S_RUN: begin
                        if (cnt_zero) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // The issuing instruction is still on issue_valid here; leaving
                        // through IDLE guarantees it is never issued a second time.
                        if (!bus.hold) begin
                            state     <= S_IDLE;
                            retired_q <= retired_q + 32'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy         = accept || (state == S_RUN);
    assign bus.result_valid = (state == S_DONE) && !bus.kill;
    assign bus.unit_start   = start_q;
    assign bus.unit_abort   = abort_q;
    assign bus.res_sel      = cls_q;
    assign bus.result_rd    = rd_q;
    assign bus.retired      = retired_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle-count model.
module tb_fpu_sequencer;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fpu_sequencer_if bus ();

    fpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit iv, int cls, int rd, bit k, bit h, bit r);
        bus.issue_valid = iv;
        bus.issue_class = 3'(cls);
        bus.issue_rd    = 5'(rd);
        bus.kill        = k;
        bus.hold        = h;
        rst             = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_tab(int c);
        case (c)
            1:       return 3;
            2:       return 4;
            3:       return 5;
            4:       return 12;
            5:       return 16;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: one op in flight, identified by its issue cycle.
    // RUN covers issue+1 .. issue+LAT, DONE begins at issue+LAT+1.
    bit          m_on = 1'b0;
    bit          m_inflight = 1'b0;
    bit          m_abort = 1'b0;
    int          m_t0, m_lat, m_cls, m_rd;
    int          m_cyc = 0;
    int unsigned m_ret = 0;

    always @(negedge clk) begin
        bit         acc;
        bit         run;
        bit         done;
        int         ic;
        logic [4:0] exp_start;
        ic   = int'(bus.issue_class);
        run  = m_inflight && (m_cyc - m_t0 <= m_lat);
        done = m_inflight && !run;
        acc  = !m_inflight && bus.issue_valid && ic >= 1 && ic <= 5 && !bus.kill;
        if (m_on) begin
            exp_start = (m_inflight && m_cyc == m_t0 + 1) ? 5'(1 << (m_cls - 1)) : 5'd0;
            check("m_busy",    32'(bus.busy),         32'(acc || run));
            check("m_start",   32'(bus.unit_start),   32'(exp_start));
            check("m_abort",   32'(bus.unit_abort),   32'(m_abort));
            check("m_valid",   32'(bus.result_valid), 32'(done && !bus.kill));
            check("m_retired", bus.retired,           m_ret);
            if (done) begin
                check("m_res_sel", 32'(bus.res_sel),   32'(m_cls));
                check("m_res_rd",  32'(bus.result_rd), 32'(m_rd));
            end
        end
        if (rst) begin
            m_on       = 1'b1;
            m_inflight = 1'b0;
            m_abort    = 1'b0;
            m_ret      = 0;
        end else if (m_on) begin
            m_abort = bus.kill && run;
            if (bus.kill) begin
                m_inflight = 1'b0;
            end else if (acc) begin
                m_inflight = 1'b1;
                m_t0       = m_cyc;
                m_cls      = ic;
                m_lat      = lat_tab(ic);
                m_rd       = int'(bus.issue_rd);
            end else if (done && !bus.hold) begin
                m_inflight = 1'b0;
                m_ret      = m_ret + 1;
            end
        end
        m_cyc++;
    end

    initial begin
        int starts;
        bit last_busy;
        bit iv;
        int cls, rd;

        drive(0, 0, 0, 0, 0, 1);
        repeat (2) next_cycle();

        // Reset values
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_busy",    32'(bus.busy),         0);
        check("rst_start",   32'(bus.unit_start),   0);
        check("rst_abort",   32'(bus.unit_abort),   0);
        check("rst_valid",   32'(bus.result_valid), 0);
        check("rst_res_sel", 32'(bus.res_sel),      0);
        check("rst_res_rd",  32'(bus.result_rd),    0);
        check("rst_retired", bus.retired,           0);
        next_cycle();

        // ADD rd=7: busy 0..3, start in 1, result in 4
        for (int k = 0; k < 6; k++) begin
            drive(k < 5, 1, 7, 0, 0, 0);
            @(negedge clk);
            check("add_busy",    32'(bus.busy),         32'(k < 4));
            check("add_start",   32'(bus.unit_start),   (k == 1) ? 32'h01 : 32'h00);
            check("add_valid",   32'(bus.result_valid), 32'(k == 4));
            if (k == 4) begin
                check("add_res_sel", 32'(bus.res_sel),   1);
                check("add_res_rd",  32'(bus.result_rd), 7);
            end
            check("add_retired", bus.retired, (k == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end

        // SQRT killed in cycle 8
        for (int k = 0; k < 13; k++) begin
            drive(k <= 8, 5, 3, k == 8, 0, 0);
            @(negedge clk);
            check("sqrt_busy",    32'(bus.busy),         32'(k <= 8));
            check("sqrt_start",   32'(bus.unit_start),   (k == 1) ? 32'h10 : 32'h00);
            check("sqrt_abort",   32'(bus.unit_abort),   32'(k == 9));
            check("sqrt_valid",   32'(bus.result_valid), 0);
            check("sqrt_retired", bus.retired,           1);
            next_cycle();
        end

        // MUL rd=12 with hold during three DONE cycles
        for (int k = 0; k < 11; k++) begin
            drive(k <= 8, 2, 12, 0, k >= 5 && k <= 7, 0);
            @(negedge clk);
            check("mul_busy",  32'(bus.busy),         32'(k <= 4));
            check("mul_start", 32'(bus.unit_start),   (k == 1) ? 32'h02 : 32'h00);
            check("mul_valid", 32'(bus.result_valid), 32'(k >= 5 && k <= 8));
            if (k >= 5 && k <= 8) begin
                check("mul_res_sel", 32'(bus.res_sel),   2);
                check("mul_res_rd",  32'(bus.result_rd), 12);
            end
            check("mul_retired", bus.retired, (k >= 9) ? 32'd2 : 32'd1);
            next_cycle();
        end

        // DIV with issue_valid held through DONE, then a new ADD
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            if (k <= 13)      drive(1, 4, 20, 0, 0, 0);
            else if (k <= 18) drive(1, 1, 1, 0, 0, 0);
            else              drive(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (k <= 13 && bus.unit_start != 5'd0) starts++;
            if (k == 13) begin
                check("div_done_busy",  32'(bus.busy),         0);
                check("div_done_valid", 32'(bus.result_valid), 1);
                check("div_res_rd",     32'(bus.result_rd),    20);
            end
            if (k == 14) check("div_next_busy",  32'(bus.busy), 1);
            if (k == 15) check("div_next_start", 32'(bus.unit_start), 32'h01);
            if (k == 19) check("div_retired",    bus.retired, 4);
            next_cycle();
        end
        check("div_start_count", 32'(starts), 1);

        // NONE and undefined classes are ignored
        for (int k = 0; k < 10; k++) begin
            drive(1, (k < 8) ? 0 : 6 + (k & 1), 5, 0, 0, 0);
            @(negedge clk);
            check("none_busy",  32'(bus.busy),         0);
            check("none_start", 32'(bus.unit_start),   0);
            check("none_valid", 32'(bus.result_valid), 0);
            next_cycle();
        end

        // Issue and kill in the same IDLE cycle
        drive(1, 3, 9, 1, 0, 0);
        @(negedge clk);
        check("ik_busy", 32'(bus.busy), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ik_start", 32'(bus.unit_start), 0);
        check("ik_busy2", 32'(bus.busy),       0);
        next_cycle();

        // Reset during an FMA run
        for (int k = 0; k < 4; k++) begin
            drive(k <= 2, 3, 9, 0, 0, k == 2);
            @(negedge clk);
            if (k == 3) begin
                check("rr_busy",    32'(bus.busy),         0);
                check("rr_start",   32'(bus.unit_start),   0);
                check("rr_abort",   32'(bus.unit_abort),   0);
                check("rr_valid",   32'(bus.result_valid), 0);
                check("rr_res_sel", 32'(bus.res_sel),      0);
                check("rr_res_rd",  32'(bus.result_rd),    0);
                check("rr_retired", bus.retired,           0);
            end
            next_cycle();
        end

        // Randomized traffic; the model process checks every cycle
        last_busy = 1'b0;
        iv  = 1'b0;
        cls = 0;
        rd  = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_busy) begin
                iv  = ($urandom_range(0, 3) != 0);
                cls = int'($urandom_range(0, 7));
                rd  = int'($urandom_range(0, 31));
            end
            drive(iv, cls, rd, $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 299) == 0);
            @(negedge clk);
            last_busy = bus.busy;
            next_cycle();
        end

        drive(0, 0, 0, 0, 0, 0);
        repeat (3) next_cycle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
